// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the MEM-stage load/store port.
// Word-organised RAM with byte/half/word access, sign/zero extension on loads,
// a configurable number of wait states and a stall request toward the pipeline.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (misaligned H/W accesses are
// suppressed and flagged on err_o together with ack_o).
//
// Handshake: a request (mem_r_ena_i | mem_w_ena_i) is sampled only in IDLE.
// While hold_req_o=1 the requester keeps its inputs stable; the copy latched in
// IDLE is what the access uses. ack_o pulses for exactly one cycle (RESP) on
// completion; the next request may be presented in the cycle right after RESP.
module dmem_resp #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_100MHz,
  input  logic        arst_n,
  input  logic        mem_r_ena_i,
  input  logic [31:0] mem_r_addr_i,
  input  logic        mem_w_ena_i,
  input  logic [31:0] mem_w_addr_i,
  input  logic [31:0] mem_w_data_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] mem_r_data_o,
  output logic        ack_o,
  output logic        hold_req_o,
  output logic        err_o,
  output logic [1:0]  state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_wr;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic [2:0]  lat_f3;

  logic [31:0] ram [DEPTH];

  logic        req;
  logic        commit;
  logic        cur_wr;
  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  logic [2:0]  cur_f3;
  logic [AW-1:0] word_idx;
  logic [1:0]  lane;
  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rword;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ld_data;
  logic        unused;

  assign req        = mem_r_ena_i | mem_w_ena_i;
  assign hold_req_o = ((state == S_IDLE) && req) || (state == S_WAIT);
  assign state_dbg  = state;

  // Select the access operands: live inputs when committing straight from IDLE
  // (zero wait states), otherwise the copy latched when the request was taken.
  always_comb begin
    cur_wr   = lat_wr;
    cur_addr = lat_addr;
    cur_data = lat_data;
    cur_f3   = lat_f3;
    if (state == S_IDLE) begin
      cur_wr   = mem_w_ena_i;
      cur_addr = mem_w_ena_i ? mem_w_addr_i : mem_r_addr_i;
      cur_data = mem_w_data_i;
      cur_f3   = funct3_i;
    end
  end

  // Commit happens on the edge that enters RESP.
  assign commit = ((state == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                  ((state == S_WAIT) && (cnt == 4'd0));

  assign word_idx = cur_addr[AW+1:2];
  assign lane     = cur_addr[1:0];
  assign is_byte  = (cur_f3 == 3'b000) || (cur_f3 == 3'b100);
  assign is_half  = (cur_f3 == 3'b001) || (cur_f3 == 3'b101);
  assign unused   = ^{cur_addr[31:AW+2]};

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = (is_half && cur_addr[0]) ||
                      (!is_byte && !is_half && (cur_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Byte-lane enables and lane-replicated store data; unlisted codes act as W.
  always_comb begin
    wmask = 4'b1111;
    wdata = cur_data;
    if (is_byte) begin
      wmask = 4'b0001 << lane;
      wdata = {4{cur_data[7:0]}};
    end else if (is_half) begin
      wmask = cur_addr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{cur_data[15:0]}};
    end
  end

  // Load extraction and sign/zero extension (funct3[2] selects unsigned).
  always_comb begin
    rword   = ram[word_idx];
    rbyte   = rword[{lane, 3'b000} +: 8];
    rhalf   = cur_addr[1] ? rword[31:16] : rword[15:0];
    ld_data = rword;
    if (is_byte) begin
      ld_data = cur_f3[2] ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
    end else if (is_half) begin
      ld_data = cur_f3[2] ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
    end
  end

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk_100MHz) begin
    if (commit && cur_wr && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) ram[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Control FSM with registered ack/err/load-data outputs.
  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      lat_wr       <= 1'b0;
      lat_addr     <= 32'd0;
      lat_data     <= 32'd0;
      lat_f3       <= 3'd0;
      mem_r_data_o <= 32'd0;
      ack_o        <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      if (commit) begin
        ack_o <= 1'b1;
        err_o <= misaligned;
        if (!cur_wr && !misaligned) mem_r_data_o <= ld_data;
      end
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_wr   <= mem_w_ena_i;
            lat_addr <= mem_w_ena_i ? mem_w_addr_i : mem_r_addr_i;
            lat_data <= mem_w_data_i;
            lat_f3   <= funct3_i;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: instance 0 with two wait states, instance 1 with none.
// A byte-array reference model predicts load data and error flags.
module tb_dmem_resp;

  localparam int DEPTH = 1024;
  localparam int NB    = DEPTH * 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst_n;
  logic [1:0]        r_ena, w_ena, ack, hold, err;
  logic [1:0][31:0]  r_addr, w_addr, w_data, rdata;
  logic [1:0][2:0]   f3;
  logic [1:0][1:0]   st;

  dmem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut0 (
    .clk_100MHz(clk), .arst_n(rst_n[0]),
    .mem_r_ena_i(r_ena[0]), .mem_r_addr_i(r_addr[0]),
    .mem_w_ena_i(w_ena[0]), .mem_w_addr_i(w_addr[0]), .mem_w_data_i(w_data[0]),
    .funct3_i(f3[0]), .mem_r_data_o(rdata[0]), .ack_o(ack[0]),
    .hold_req_o(hold[0]), .err_o(err[0]), .state_dbg(st[0])
  );

  dmem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut1 (
    .clk_100MHz(clk), .arst_n(rst_n[1]),
    .mem_r_ena_i(r_ena[1]), .mem_r_addr_i(r_addr[1]),
    .mem_w_ena_i(w_ena[1]), .mem_w_addr_i(w_addr[1]), .mem_w_data_i(w_data[1]),
    .funct3_i(f3[1]), .mem_r_data_o(rdata[1]), .ack_o(ack[1]),
    .hold_req_o(hold[1]), .err_o(err[1]), .state_dbg(st[1])
  );

  int errors = 0;
  int checks = 0;
  int ack_cnt1 = 0;

  always @(negedge clk) if (ack[1] === 1'b1) ack_cnt1++;

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  mb [2][NB];
  logic [31:0] exp_rd [2];
  logic [31:0] exp_q [$];

  function automatic void model_access(input int d, input logic wr, input logic rd,
                                       input logic [31:0] wa, input logic [31:0] ra,
                                       input logic [31:0] wd, input logic [2:0] fc,
                                       output logic [31:0] exp_d, output logic exp_e);
    logic [31:0] a;
    int b;
    int size;
    logic mis;
    logic [31:0] v;
    a    = wr ? wa : ra;
    b    = int'(a % NB);
    size = (fc == 3'b000 || fc == 3'b100) ? 1 : (fc == 3'b001 || fc == 3'b101) ? 2 : 4;
    mis  = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    mis = (b % size) != 0;
`endif
    b = b - (b % size);
    if (!mis) begin
      if (wr) begin
        for (int i = 0; i < size; i++) mb[d][b+i] = wd[8*i +: 8];
      end else if (rd) begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mb[d][b+i];
        if (size < 4 && !fc[2] && v[8*size-1])
          for (int i = 8*size; i < 32; i++) v[i] = 1'b1;
        exp_rd[d] = v;
      end
    end
    exp_d = exp_rd[d];
    exp_e = mis;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after RESP.
  task automatic drive(input int d, input logic wr, input logic rd,
                       input logic [31:0] wa, input logic [31:0] ra, input logic [31:0] wd,
                       input logic [2:0] fc, output int lat, output int hcnt,
                       output logic [31:0] rd_o, output logic er_o,
                       output logic hold_resp, output logic ack_next);
    logic got;
    got = 1'b0; lat = 0; hcnt = 0;
    w_ena[d] = wr; r_ena[d] = rd; w_addr[d] = wa; r_addr[d] = ra; w_data[d] = wd; f3[d] = fc;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (hold[d] === 1'b1) hcnt++;
      @(posedge clk); #1;
      lat++;
      if (ack[d] === 1'b1) got = 1'b1;
    end
    rd_o = rdata[d];
    er_o = err[d];
    w_ena[d] = 1'b0; r_ena[d] = 1'b0;
    #1 hold_resp = hold[d];
    @(posedge clk); #1;
    ack_next = ack[d];
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL timeout dut%0d: no ack_o within %0d cycles", d, lat);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 2'b00;
    r_ena = '0; w_ena = '0; r_addr = '0; w_addr = '0; w_data = '0; f3 = '0;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    #12;
    for (int d = 0; d < 2; d++) begin
      checks++; if (ack[d] !== 1'b0) begin errors++; $display("FAIL reset_ack dut%0d: got %b want 0", d, ack[d]); end
      checks++; if (hold[d] !== 1'b0) begin errors++; $display("FAIL reset_hold dut%0d: got %b want 0", d, hold[d]); end
      checks++; if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d: got %b want 0", d, err[d]); end
      checks++; if (rdata[d] !== 32'd0) begin errors++; $display("FAIL reset_rdata dut%0d: got %h want 0", d, rdata[d]); end
    end
    @(negedge clk); rst_n = 2'b11;
    @(posedge clk); #1;
  endtask

  task automatic init_mem();
    int lat, hc; logic [31:0] rv, ed; logic ev, hr, an;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 32; w++) begin
        logic [31:0] val;
        val = $urandom;
        model_access(d, 1'b1, 1'b0, 32'(w*4), 32'd0, val, 3'b010, ed, ev);
        drive(d, 1'b1, 1'b0, 32'(w*4), 32'd0, val, 3'b010, lat, hc, rv, ev, hr, an);
      end
    end
  endtask

  task automatic test_store_load();
    int lat, hc; logic [31:0] rv, ed; logic ev, ee, hr, an;
    logic [2:0]  codes [6];
    logic [31:0] addrs [6];
    logic [31:0] wants [6];
    codes = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b001};
    addrs = '{32'h13, 32'h11, 32'h11, 32'h12, 32'h10, 32'h10};
    wants = '{32'h0000007F, 32'h000000BE, 32'hFFFFFFBE, 32'h00007FAD, 32'h0000BEEF, 32'hFFFFBEEF};
    model_access(0, 1'b1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 3'b010, ed, ee);
    drive(0, 1'b1, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 3'b010, lat, hc, rv, ev, hr, an);
    checks++; if (lat != 3) begin errors++; $display("FAIL sw_latency: got %0d want 3", lat); end
    checks++; if (hc != 3) begin errors++; $display("FAIL sw_hold_cycles: got %0d want 3", hc); end
    checks++; if (hr !== 1'b0) begin errors++; $display("FAIL resp_hold: got %b want 0", hr); end
    checks++; if (an !== 1'b0) begin errors++; $display("FAIL ack_one_cycle: got %b want 0", an); end
    model_access(0, 1'b0, 1'b1, 32'd0, 32'h10, 32'd0, 3'b010, ed, ee);
    drive(0, 1'b0, 1'b1, 32'd0, 32'h10, 32'd0, 3'b010, lat, hc, rv, ev, hr, an);
    checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_0x10: got %h want deadbeef", rv); end
    model_access(0, 1'b1, 1'b0, 32'h13, 32'd0, 32'h7F, 3'b000, ed, ee);
    drive(0, 1'b1, 1'b0, 32'h13, 32'd0, 32'h7F, 3'b000, lat, hc, rv, ev, hr, an);
    for (int i = 0; i < 6; i++) begin
      model_access(0, 1'b0, 1'b1, 32'd0, addrs[i], 32'd0, codes[i], ed, ee);
      drive(0, 1'b0, 1'b1, 32'd0, addrs[i], 32'd0, codes[i], lat, hc, rv, ev, hr, an);
      checks++;
      if (rv !== wants[i]) begin
        errors++; $display("FAIL subword_load[%0d] f3=%b addr=%h: got %h want %h", i, codes[i], addrs[i], rv, wants[i]);
      end
    end
  endtask

  task automatic test_both_enables();
    int lat, hc; logic [31:0] rv, ed; logic ev, ee, hr, an;
    model_access(0, 1'b1, 1'b1, 32'h20, 32'h40, 32'h12345678, 3'b010, ed, ee);
    exp_q.push_back(ed);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h40, 32'h12345678, 3'b010, lat, hc, rv, ev, hr, an);
    ed = exp_q.pop_front();
    checks++; if (rv !== ed) begin errors++; $display("FAIL both_rdata_unchanged: got %h want %h", rv, ed); end
    model_access(0, 1'b0, 1'b1, 32'd0, 32'h20, 32'd0, 3'b010, ed, ee);
    drive(0, 1'b0, 1'b1, 32'd0, 32'h20, 32'd0, 3'b010, lat, hc, rv, ev, hr, an);
    checks++; if (rv !== 32'h12345678) begin errors++; $display("FAIL both_write_done: got %h want 12345678", rv); end
  endtask

  task automatic test_wrap();
    int lat, hc; logic [31:0] rv, ed; logic ev, ee, hr, an;
    model_access(0, 1'b1, 1'b0, 32'h1000, 32'd0, 32'h1234, 3'b010, ed, ee);
    drive(0, 1'b1, 1'b0, 32'h1000, 32'd0, 32'h1234, 3'b010, lat, hc, rv, ev, hr, an);
    model_access(0, 1'b0, 1'b1, 32'd0, 32'h0, 32'd0, 3'b010, ed, ee);
    drive(0, 1'b0, 1'b1, 32'd0, 32'h0, 32'd0, 3'b010, lat, hc, rv, ev, hr, an);
    checks++; if (rv !== 32'h00001234) begin errors++; $display("FAIL addr_wrap: got %h want 00001234", rv); end
  endtask

  task automatic test_misalign();
    int lat, hc; logic [31:0] rv, ed; logic ev, ee, hr, an;
    logic [31:0] addrs [3];
    logic [2:0]  codes [3];
    addrs = '{32'h2, 32'h11, 32'h5};
    codes = '{3'b010, 3'b001, 3'b101};
    for (int i = 0; i < 3; i++) begin
      model_access(0, 1'b0, 1'b1, 32'd0, addrs[i], 32'd0, codes[i], ed, ee);
      drive(0, 1'b0, 1'b1, 32'd0, addrs[i], 32'd0, codes[i], lat, hc, rv, ev, hr, an);
      checks++; if (rv !== ed) begin errors++; $display("FAIL misalign_data[%0d]: got %h want %h", i, rv, ed); end
      checks++; if (ev !== ee) begin errors++; $display("FAIL misalign_err[%0d]: got %b want %b", i, ev, ee); end
      checks++; if (an !== 1'b0) begin errors++; $display("FAIL misalign_err_clear[%0d]: ack after RESP %b want 0", i, an); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, hc; logic [31:0] rv, ed; logic ev, ee, hr, an;
    w_ena[0] = 1'b1; w_addr[0] = 32'h8; w_data[0] = 32'hAAAA5555; f3[0] = 3'b010;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (hold[0] !== 1'b1) begin errors++; $display("FAIL mid_hold_in_wait: got %b want 1", hold[0]); end
    w_ena[0] = 1'b0;
    #1 rst_n[0] = 1'b0;
    #1;
    exp_rd[0] = 32'd0;
    checks++; if (ack[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_ack: got %b want 0", ack[0]); end
    checks++; if (hold[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_hold: got %b want 0", hold[0]); end
    checks++; if (rdata[0] !== 32'd0) begin errors++; $display("FAIL mid_reset_rdata: got %h want 0", rdata[0]); end
    @(negedge clk); rst_n[0] = 1'b1;
    @(posedge clk); #1;
    checks++; if (ack[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_no_late_ack: got %b want 0", ack[0]); end
    model_access(0, 1'b0, 1'b1, 32'd0, 32'h8, 32'd0, 3'b010, ed, ee);
    drive(0, 1'b0, 1'b1, 32'd0, 32'h8, 32'd0, 3'b010, lat, hc, rv, ev, hr, an);
    checks++; if (rv !== ed) begin errors++; $display("FAIL mid_reset_discard: got %h want %h", rv, ed); end
  endtask

  task automatic test_back_to_back();
    int lat, hc, start; logic [31:0] rv, ed; logic ev, ee, hr, an;
    logic        wrs [3];
    logic [31:0] ads [3];
    wrs = '{1'b1, 1'b0, 1'b0};
    ads = '{32'h4, 32'h4, 32'h8};
    start = ack_cnt1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] val;
      val = $urandom;
      model_access(1, wrs[i], !wrs[i], ads[i], ads[i], val, 3'b010, ed, ee);
      drive(1, wrs[i], !wrs[i], ads[i], ads[i], val, 3'b010, lat, hc, rv, ev, hr, an);
      checks++; if (lat != 1) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want 1", i, lat); end
      checks++; if (hc != 1) begin errors++; $display("FAIL b2b_hold[%0d]: got %0d want 1", i, hc); end
      checks++; if (rv !== ed) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rv, ed); end
    end
    checks++; if (ack_cnt1 - start != 3) begin errors++; $display("FAIL b2b_ack_count: got %0d want 3", ack_cnt1 - start); end
  endtask

  task automatic test_random();
    int lat, hc; logic [31:0] rv, ed, wa, ra, wd; logic ev, ee, hr, an, wr, rd;
    logic [2:0] codes [5];
    logic [2:0] fc;
    int kind;
    codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        kind = $urandom_range(0, 4);
        wr = (kind >= 2);
        rd = (kind <= 1) || (kind == 4);
        fc = codes[$urandom_range(0, 4)];
        wa = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
        ra = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
        wd = $urandom;
        model_access(d, wr, rd, wa, ra, wd, fc, ed, ee);
        exp_q.push_back(ed);
        drive(d, wr, rd, wa, ra, wd, fc, lat, hc, rv, ev, hr, an);
        ed = exp_q.pop_front();
        checks++; if (rv !== ed) begin errors++; $display("FAIL rand_data dut%0d #%0d: got %h want %h", d, n, rv, ed); end
        checks++; if (ev !== ee) begin errors++; $display("FAIL rand_err dut%0d #%0d: got %b want %b", d, n, ev, ee); end
        checks++; if (lat != (d == 0 ? 3 : 1)) begin errors++; $display("FAIL rand_latency dut%0d #%0d: got %0d want %0d", d, n, lat, (d == 0 ? 3 : 1)); end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    init_mem();
    test_store_load();
    test_both_enables();
    test_wrap();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
